wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the prz RISC-V core and the sole driver of the register file write port (`wen`, `rdest_addr`, `wdata`). It merges single-cycle ALU results with in-order load responses from data memory, aligning and extending sub-word load data. It keeps an in-order queue of outstanding loads, which doubles as a scoreboard: decode queries it to stall on load-use hazards.

## Interface
- `LD_DEPTH`, default 2: number of outstanding loads the queue holds (≥1).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `alu_ready` out 1: ALU result accepted this cycle.
- `ld_req_valid` in 1: a load is being issued to memory.
- `ld_req_rd` in 5: load destination register.
- `ld_req_funct3` in 3: load type (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- `ld_req_addr_lo` in 2: address bits [1:0].
- `ld_req_ready` out 1: the queue can accept a load.
- `mem_rsp_valid` in 1: memory read data present.
- `mem_rsp_data` in 32: raw aligned memory word.
- `mem_rsp_ready` out 1: the response is accepted.
- `rs1_addr`, `rs2_addr` in 5: decode hazard query.
- `rs1_busy`, `rs2_busy` out 1: the queried register has a pending load write.
- `wen` out 1: register file write enable (registered).
- `rdest_addr` out 5: register file write address (registered).
- `wdata` out 32: register file write data (registered).

## Operation
- Load queue: FIFO of {rd, funct3, addr_lo}, depth LD_DEPTH.
  - Push on `ld_req_valid && ld_req_ready`.
  - `ld_req_ready = !full`, computed from the current cycle's state only. There is no same-cycle pass-through when full, even if a pop occurs.
- `mem_rsp_ready = !empty`.
  - On `mem_rsp_valid && mem_rsp_ready`: pop the head entry and load the load-result register (LRR) with {rd, aligned data}.
  - A response arriving while the queue is empty is dropped.
- Alignment (byte offset b = addr_lo, half offset h = addr_lo[1]):
  - LB: sign-extend `data[8b+7:8b]`.
  - LBU: zero-extend `data[8b+7:8b]`.
  - LH: sign-extend `data[16h+15:16h]`.
  - LHU: zero-extend `data[16h+15:16h]`.
  - LW and all other funct3 codes: `data` unchanged.
  - `addr_lo[0]` is ignored for halfword loads.
- Write-port arbitration: a valid LRR always wins.
  - `alu_ready = !lrr_valid`.
  - LRR is valid for exactly one cycle, then drains, so the ALU stalls at most one cycle per load.
- Output register, loaded every cycle:
  - LRR valid: wen=(rd≠0), rdest_addr=rd, wdata=load data.
  - Otherwise, `alu_valid` set: wen=(alu_rd≠0), rdest_addr=alu_rd, wdata=alu_data.
  - Otherwise: wen=0; rdest_addr and wdata hold their previous values.
- Scoreboard: `rsX_busy` = (rsX_addr≠0) and rsX_addr matches any of:
  - a valid queue entry rd,
  - the LRR rd,
  - the output register rd while it carries a load write.
- Destination x0: the load is still queued and its response consumed, but x0 never reports busy and is never written.

## Timing
- Reset values: `wen`=0, `rdest_addr`=0, `wdata`=0, queue empty, LRR invalid.
  - Consequently after reset: `ld_req_ready`=1, `mem_rsp_ready`=0, `alu_ready`=1, busy outputs 0.
- Reset mid-operation flushes all pending loads. Responses arriving later are dropped.
- ALU path: accepted in cycle N → `wen`/`rdest_addr`/`wdata` valid in N+1 → register file updated at the end of N+1.
- Load path: response accepted in N → LRR in N+1 (ALU stalled in N+1) → output register in N+2.
- Busy clears in the cycle after the load's output-register cycle, i.e. once the register file holds the value.
- Same-cycle push and pop are both honoured; occupancy is unchanged.
- Combinational outputs: `alu_ready`, `ld_req_ready`, `mem_rsp_ready` and busy flags depend only on registered state plus the `rsX_addr` inputs.

## Configuration
- Macro: `WB_SUBWORD_EN`.
- Defined: full LB/LH/LBU/LHU/LW alignment and extension, as described above.
- Undefined:
  - funct3 and addr_lo are not stored in the queue.
  - Every load writes `mem_rsp_data` unchanged (LW only).
  - Sub-word loads must trap upstream.

## Test plan
- Reset, then ALU writes x5=0x1234_5678: `wen`=1, `rdest_addr`=5, `wdata`=0x12345678 exactly one cycle later. An ALU write to x0 gives `wen`=0.
- LB x3 with addr_lo=3, response 0x80FF_0000: x3=0xFFFF_FF80. The same word with LBU gives 0x0000_0080; LHU with addr_lo=2 gives 0x0000_80FF.
- Issue two loads (LD_DEPTH=2): `ld_req_ready`=0. A third request is held until the first response; responses write rd in issue order.
- Load to x7 pending, query `rs1_addr`=7: `rs1_busy`=1 until the cycle after `wen`=1 for x7, then 0. Query x0: always 0.
- Response and `alu_valid` collide: the load writes first, `alu_ready`=0 for one cycle, and the ALU result writes on the following cycle.
- `rst` asserted with one load queued, then a response arrives: response dropped, `wen` stays 0, `mem_rsp_ready`=0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results with in-order load responses, drives the register file
// write port and answers load-use hazard queries. Macro WB_SUBWORD_EN enables sub-word load alignment.
module wb_stage #(
    parameter int unsigned LD_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_req_valid,
    input  logic [4:0]  ld_req_rd,
    input  logic [2:0]  ld_req_funct3,
    input  logic [1:0]  ld_req_addr_lo,
    output logic        ld_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        mem_rsp_ready,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        wen,
    output logic [4:0]  rdest_addr,
    output logic [31:0] wdata
);
    localparam int unsigned PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(LD_DEPTH + 1);

    logic [4:0]          q_rd [LD_DEPTH];
    logic [LD_DEPTH-1:0] q_vld;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                push;
    logic                pop;

    logic                lrr_valid;
    logic [4:0]          lrr_rd;
    logic [31:0]         lrr_data;
    logic                out_load;
    logic [31:0]         load_data;

`ifdef WB_SUBWORD_EN
    logic [2:0] q_f3  [LD_DEPTH];
    logic [1:0] q_alo [LD_DEPTH];

    // Select the addressed byte/halfword of the raw word and extend it per load type.
    function automatic logic [31:0] align_load(input logic [2:0] f3, input logic [1:0] alo,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[7:0];
        case (alo)
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            2'd3:    b = d[31:24];
            default: b = d[7:0];
        endcase
        h = alo[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  align_load = {{24{b[7]}}, b};
            3'b001:  align_load = {{16{h[15]}}, h};
            3'b100:  align_load = {24'd0, b};
            3'b101:  align_load = {16'd0, h};
            default: align_load = d;
        endcase
    endfunction

    assign load_data = align_load(q_f3[rd_ptr], q_alo[rd_ptr], mem_rsp_data);
`else
    logic unused_subword;
    assign unused_subword = ^{ld_req_funct3, ld_req_addr_lo};
    assign load_data      = mem_rsp_data;
`endif

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        next_ptr = (p == PTR_W'(LD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign ld_req_ready  = (count != CNT_W'(LD_DEPTH));
    assign mem_rsp_ready = (count != '0);
    assign alu_ready     = !lrr_valid;
    assign push          = ld_req_valid && ld_req_ready;
    assign pop           = mem_rsp_valid && mem_rsp_ready;

    // Queue control; push and pop never target the same slot since full blocks push and empty blocks pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_vld  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= next_ptr(rd_ptr);
            end
            if (push) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]  <= ld_req_rd;
`ifdef WB_SUBWORD_EN
            q_f3[wr_ptr]  <= ld_req_funct3;
            q_alo[wr_ptr] <= ld_req_addr_lo;
`endif
        end
        if (pop) begin
            lrr_rd   <= q_rd[rd_ptr];
            lrr_data <= load_data;
        end
    end

    // Output register: a pending load result always takes the write port ahead of the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            lrr_valid  <= 1'b0;
            out_load   <= 1'b0;
            wen        <= 1'b0;
            rdest_addr <= '0;
            wdata      <= '0;
        end else begin
            lrr_valid <= pop;
            out_load  <= lrr_valid;
            if (lrr_valid) begin
                wen        <= (lrr_rd != 5'd0);
                rdest_addr <= lrr_rd;
                wdata      <= lrr_data;
            end else if (alu_valid) begin
                wen        <= (alu_rd != 5'd0);
                rdest_addr <= alu_rd;
                wdata      <= alu_data;
            end else begin
                wen <= 1'b0;
            end
        end
    end

    // A register is busy from load issue until the register file holds the loaded value.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int unsigned i = 0; i < LD_DEPTH; i++) begin
            if (q_vld[PTR_W'(i)] && (q_rd[PTR_W'(i)] == rs1_addr)) rs1_busy = 1'b1;
            if (q_vld[PTR_W'(i)] && (q_rd[PTR_W'(i)] == rs2_addr)) rs2_busy = 1'b1;
        end
        if (lrr_valid && (lrr_rd == rs1_addr)) rs1_busy = 1'b1;
        if (lrr_valid && (lrr_rd == rs2_addr)) rs2_busy = 1'b1;
        if (out_load && (rdest_addr == rs1_addr)) rs1_busy = 1'b1;
        if (out_load && (rdest_addr == rs2_addr)) rs2_busy = 1'b1;
        if (rs1_addr == 5'd0) rs1_busy = 1'b0;
        if (rs2_addr == 5'd0) rs2_busy = 1'b0;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: alignment vector table, write scoreboard, and directed
// sequences for queue depth, busy timing, write-port collision and mid-operation reset.
module tb_wb_stage;
    localparam int unsigned LD_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_req_valid;
    logic [4:0]  ld_req_rd;
    logic [2:0]  ld_req_funct3;
    logic [1:0]  ld_req_addr_lo;
    logic        ld_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        wen;
    logic [4:0]  rdest_addr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    wb_stage #(.LD_DEPTH(LD_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_req_valid(ld_req_valid), .ld_req_rd(ld_req_rd), .ld_req_funct3(ld_req_funct3),
        .ld_req_addr_lo(ld_req_addr_lo), .ld_req_ready(ld_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wen(wen), .rdest_addr(rdest_addr), .wdata(wdata)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] data;
        logic [31:0] exp_sub;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[13];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        sb.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid      = 1'b0;
        alu_rd         = '0;
        alu_data       = '0;
        ld_req_valid   = 1'b0;
        ld_req_rd      = '0;
        ld_req_funct3  = 3'b010;
        ld_req_addr_lo = '0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
    endtask

    task automatic issue_lw(input logic [4:0] rd);
        ld_req_valid   = 1'b1;
        ld_req_rd      = rd;
        ld_req_funct3  = 3'b010;
        ld_req_addr_lo = 2'd0;
    endtask

    // Scoreboard: every register file write must match the oldest expected write.
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%08h, want no write", rdest_addr, wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("sb_rd", 32'(rdest_addr), 32'(e.rd));
                check("sb_data", wdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        logic [4:0]  rd;
        logic [31:0] req;

        vecs[0]  = '{3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
        vecs[1]  = '{3'b100, 2'd3, 32'h80FF_0000, 32'h0000_0080};
        vecs[2]  = '{3'b101, 2'd2, 32'h80FF_0000, 32'h0000_80FF};
        vecs[3]  = '{3'b001, 2'd2, 32'h80FF_0000, 32'hFFFF_80FF};
        vecs[4]  = '{3'b001, 2'd3, 32'h80FF_0000, 32'hFFFF_80FF};
        vecs[5]  = '{3'b000, 2'd0, 32'h1234_567F, 32'h0000_007F};
        vecs[6]  = '{3'b000, 2'd1, 32'h1234_A57F, 32'hFFFF_FFA5};
        vecs[7]  = '{3'b100, 2'd2, 32'h12F4_5678, 32'h0000_00F4};
        vecs[8]  = '{3'b001, 2'd0, 32'h0000_8001, 32'hFFFF_8001};
        vecs[9]  = '{3'b101, 2'd0, 32'hABCD_7FFF, 32'h0000_7FFF};
        vecs[10] = '{3'b010, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[11] = '{3'b011, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[12] = '{3'b110, 2'd3, 32'h8765_4321, 32'h8765_4321};

        // Reset state
        idle();
        rst      = 1'b1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd7;
        tick(); tick(); tick();
        check("rst_wen", 32'(wen), 32'd0);
        check("rst_rdest", 32'(rdest_addr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ld_req_ready", 32'(ld_req_ready), 32'd1);
        check("rst_mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_busy1", 32'(rs1_busy), 32'd0);
        check("rst_busy2", 32'(rs2_busy), 32'd0);

        // ALU write and ALU write to x0
        tick();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
        check("alu_ready", 32'(alu_ready), 32'd1);
        expect_wr(5'd5, 32'h1234_5678);
        tick();
        alu_rd = 5'd0; alu_data = 32'h0000_FFFF;
        check("alu_wen", 32'(wen), 32'd1);
        check("alu_rdest", 32'(rdest_addr), 32'd5);
        check("alu_wdata", wdata, 32'h1234_5678);
        tick();
        alu_valid = 1'b0;
        check("alu_x0_wen", 32'(wen), 32'd0);
        tick();
        check("idle_wen", 32'(wen), 32'd0);
        check("idle_rdest_hold", 32'(rdest_addr), 32'd0);
        check("idle_wdata_hold", wdata, 32'h0000_FFFF);

        // Alignment table: issue, respond, then the write lands two cycles after the response
        for (int i = 0; i < 13; i++) begin
            rd = 5'(i + 1);
`ifdef WB_SUBWORD_EN
            req = vecs[i].exp_sub;
`else
            req = vecs[i].data;
`endif
            ld_req_valid = 1'b1; ld_req_rd = rd;
            ld_req_funct3 = vecs[i].f3; ld_req_addr_lo = vecs[i].alo;
            check("vec_ld_req_ready", 32'(ld_req_ready), 32'd1);
            tick();
            ld_req_valid  = 1'b0;
            mem_rsp_valid = 1'b1; mem_rsp_data = vecs[i].data;
            check("vec_mem_rsp_ready", 32'(mem_rsp_ready), 32'd1);
            expect_wr(rd, req);
            tick();
            mem_rsp_valid = 1'b0;
            check("vec_alu_stall", 32'(alu_ready), 32'd0);
            check("vec_wen_early", 32'(wen), 32'd0);
            tick();
            check("vec_wen", 32'(wen), 32'd1);
            check("vec_wdata", wdata, req);
            tick();
        end

        // Queue depth: full blocks a third load, with no pass-through on the popping cycle
        issue_lw(5'd10);
        tick();
        issue_lw(5'd11);
        check("q_ready_one", 32'(ld_req_ready), 32'd1);
        tick();
        issue_lw(5'd12);
        rs2_addr = 5'd12;
        #1;
        check("q_full", 32'(ld_req_ready), 32'd0);
        check("q_held_not_busy", 32'(rs2_busy), 32'd0);
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA0A0_000A;
        expect_wr(5'd10, 32'hA0A0_000A);
        check("q_no_passthru", 32'(ld_req_ready), 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        check("q_ready_after_pop", 32'(ld_req_ready), 32'd1);
        tick();
        ld_req_valid = 1'b0;
        check("q_third_busy", 32'(rs2_busy), 32'd1);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hB1B1_000B;
        expect_wr(5'd11, 32'hB1B1_000B);
        tick();
        mem_rsp_data = 32'hC2C2_000C;
        expect_wr(5'd12, 32'hC2C2_000C);
        tick();
        mem_rsp_valid = 1'b0;
        tick(); tick(); tick();
        check("q_drained", 32'(mem_rsp_ready), 32'd0);

        // Busy timing for x7 and x0 never busy
        rs1_addr = 5'd7; rs2_addr = 5'd0;
        issue_lw(5'd7);
        #1;
        check("busy_before", 32'(rs1_busy), 32'd0);
        tick();
        ld_req_valid = 1'b0;
        check("busy_queued", 32'(rs1_busy), 32'd1);
        check("busy_x0_query", 32'(rs2_busy), 32'd0);
        tick();
        check("busy_waiting", 32'(rs1_busy), 32'd1);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0707;
        expect_wr(5'd7, 32'h0000_0707);
        tick();
        mem_rsp_valid = 1'b0;
        check("busy_lrr", 32'(rs1_busy), 32'd1);
        tick();
        check("busy_out_wen", 32'(wen), 32'd1);
        check("busy_out", 32'(rs1_busy), 32'd1);
        tick();
        check("busy_cleared", 32'(rs1_busy), 32'd0);
        issue_lw(5'd0);
        tick();
        ld_req_valid = 1'b0;
        check("x0_load_not_busy", 32'(rs2_busy), 32'd0);
        check("x0_load_queued", 32'(mem_rsp_ready), 32'd1);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_0000;
        tick();
        mem_rsp_valid = 1'b0;
        check("x0_consumed", 32'(mem_rsp_ready), 32'd0);
        tick();
        check("x0_no_write", 32'(wen), 32'd0);
        tick();

        // Load response collides with an ALU result
        issue_lw(5'd20);
        tick();
        ld_req_valid  = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h2020_2020;
        expect_wr(5'd20, 32'h2020_2020);
        tick();
        mem_rsp_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h2121_2121;
        check("col_alu_stall", 32'(alu_ready), 32'd0);
        tick();
        check("col_alu_ready", 32'(alu_ready), 32'd1);
        check("col_load_first", 32'(rdest_addr), 32'd20);
        expect_wr(5'd21, 32'h2121_2121);
        tick();
        alu_valid = 1'b0;
        check("col_alu_second", 32'(rdest_addr), 32'd21);
        check("col_alu_wdata", wdata, 32'h2121_2121);
        tick();

        // Reset with a load queued flushes it; the late response is dropped
        rs1_addr = 5'd9;
        issue_lw(5'd9);
        tick();
        ld_req_valid = 1'b0;
        check("rst_mid_queued", 32'(mem_rsp_ready), 32'd1);
        check("rst_mid_busy", 32'(rs1_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_flush", 32'(mem_rsp_ready), 32'd0);
        check("rst_mid_not_busy", 32'(rs1_busy), 32'd0);
        check("rst_mid_ld_ready", 32'(ld_req_ready), 32'd1);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h9999_9999;
        tick();
        mem_rsp_valid = 1'b0;
        check("rst_drop_wen1", 32'(wen), 32'd0);
        tick();
        check("rst_drop_wen2", 32'(wen), 32'd0);
        check("rst_drop_rsp_ready", 32'(mem_rsp_ready), 32'd0);
        tick(); tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
